// File: rtl/fir_seq_ctrl.sv
// ============================================================================
// fir_seq_ctrl : time-multiplexed FIR controller, one MAC per cycle over TAPS.
// Optional macro FIR_SAT_EN: 64-bit products/accumulator, saturating result.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fir_seq_ctrl #(
   parameter int TAPS  = 5,
   parameter int IDX_W = 3
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             io_cmd_valid,
   output logic             io_cmd_ready,
   input  logic [1:0]       io_cmd_op,
   input  logic [IDX_W-1:0] io_cmd_idx,
   input  logic [31:0]      io_cmd_data,
   output logic             io_rsp_valid,
   input  logic             io_rsp_ready,
   output logic [31:0]      io_rsp_data,
   output logic             io_busy
);

   localparam int CNT_W = (TAPS > 1) ? $clog2(TAPS) : 1;

   localparam logic [1:0] OP_LOAD  = 2'd0;
   localparam logic [1:0] OP_PUSH  = 2'd1;
   localparam logic [1:0] OP_READ  = 2'd2;
   localparam logic [1:0] OP_CLEAR = 2'd3;

   localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(TAPS - 1);

`ifdef FIR_SAT_EN
   localparam int ACC_W = 64;
`else
   localparam int ACC_W = 32;
`endif

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MAC  = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [31:0]      coef_q [TAPS];
   logic [31:0]      coef_d [TAPS];
   logic [31:0]      x_q    [TAPS];
   logic [31:0]      x_d    [TAPS];
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [31:0]      result_q, result_d;
   logic [31:0]      rsp_data_q, rsp_data_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [31:0]      coef_sel;
   logic [31:0]      x_sel;
   logic [ACC_W-1:0] prod;
   logic [ACC_W-1:0] acc_sum;
   logic [31:0]      result_next;
   logic             cmd_fire;
   logic             idx_ok;

   assign coef_sel = coef_q[cnt_q];
   assign x_sel    = x_q[cnt_q];
   assign cmd_fire = io_cmd_valid && (state_q == ST_IDLE);
   assign idx_ok   = (32'(io_cmd_idx) < 32'(TAPS));

`ifdef FIR_SAT_EN
   // Sign-extended operands give the exact signed 64-bit product.
   assign prod    = {{32{coef_sel[31]}}, coef_sel} * {{32{x_sel[31]}}, x_sel};
   assign acc_sum = acc_q + prod;

   always_comb begin
      logic signed [63:0] s;
      s = $signed(acc_sum);
      if (s > 64'sd2147483647) begin
         result_next = 32'h7FFF_FFFF;
      end else if (s < -64'sd2147483648) begin
         result_next = 32'h8000_0000;
      end else begin
         result_next = s[31:0];
      end
   end
`else
   // Low 32 bits of a signed product do not depend on signedness.
   assign prod        = coef_sel * x_sel;
   assign acc_sum     = acc_q + prod;
   assign result_next = acc_sum;
`endif

   always_comb begin
      state_d    = state_q;
      coef_d     = coef_q;
      x_d        = x_q;
      acc_d      = acc_q;
      result_d   = result_q;
      rsp_data_d = rsp_data_q;
      cnt_d      = cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (cmd_fire) begin
               case (io_cmd_op)
                  OP_LOAD: begin
                     if (idx_ok) begin
                        coef_d[io_cmd_idx] = io_cmd_data;
                     end
                  end
                  OP_PUSH: begin
                     for (int i = TAPS - 1; i >= 1; i--) begin
                        x_d[i] = x_q[i-1];
                     end
                     x_d[0]  = io_cmd_data;
                     acc_d   = '0;
                     cnt_d   = '0;
                     state_d = ST_MAC;
                  end
                  OP_READ: begin
                     rsp_data_d = result_q;
                     state_d    = ST_RESP;
                  end
                  OP_CLEAR: begin
                     for (int i = 0; i < TAPS; i++) begin
                        x_d[i] = '0;
                     end
                     result_d = '0;
                  end
                  default: begin
                  end
               endcase
            end
         end
         ST_MAC: begin
            acc_d = acc_sum;
            if (cnt_q == LAST_TAP) begin
               result_d = result_next;
               state_d  = ST_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_RESP: begin
            if (io_rsp_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         acc_q      <= '0;
         result_q   <= '0;
         rsp_data_q <= '0;
         cnt_q      <= '0;
         for (int i = 0; i < TAPS; i++) begin
            coef_q[i] <= '0;
            x_q[i]    <= '0;
         end
      end else begin
         state_q    <= state_d;
         acc_q      <= acc_d;
         result_q   <= result_d;
         rsp_data_q <= rsp_data_d;
         cnt_q      <= cnt_d;
         for (int i = 0; i < TAPS; i++) begin
            coef_q[i] <= coef_d[i];
            x_q[i]    <= x_d[i];
         end
      end
   end

   assign io_cmd_ready = (state_q == ST_IDLE);
   assign io_busy      = (state_q == ST_MAC);
   assign io_rsp_valid = (state_q == ST_RESP);
   assign io_rsp_data  = rsp_data_q;

endmodule

`default_nettype wire
